tdc_therm_encoder: RTL and testbench

Downstream consumer of the carry-chain delay line: registers the raw tap snapshot, resynchronises it, optionally bubble-filters it, and encodes the position and polarity of the thermometer transition into a fine code. Each fine code is tagged with a free-running coarse cycle counter. Hits are buffered in a small FIFO with a valid/ready output. It sits between the delay-line primitive and the timestamp packer/readout logic.

---
 rtl/tdc_therm_encoder.sv | 193 +++++++++++++++++++
 tb/tb_tdc_therm_encoder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_therm_encoder.sv
// tdc_therm_encoder
// Registers and resynchronises a carry-chain tap snapshot, optionally
// bubble-filters it, and encodes the thermometer transition into a fine
// code. Each fine code is tagged with a free-running coarse count, and hits
// are queued in a small FIFO that presents a valid/ready interface.
// Optional feature macro: TDC_BUBBLE_FILTER_EN enables a 3-tap majority
// bubble filter in stage S3. Without it S3 is a plain register, so the
// pipeline latency is the same either way.
module tdc_therm_encoder #(
    parameter int N        = 128,
    parameter int COARSE_W = 16,
    parameter int DEPTH    = 4,
    localparam int FINE_W  = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        taps,
    input  logic                arm,
    output logic                hit_valid,
    input  logic                hit_ready,
    output logic [FINE_W-1:0]   hit_fine,
    output logic                hit_rise,
    output logic [COARSE_W-1:0] hit_coarse,
    output logic [7:0]          drop_cnt
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = FINE_W + 1 + COARSE_W;

`ifdef TDC_BUBBLE_FILTER_EN
    // Majority of each tap and its two neighbours. The end taps pass
    // through unchanged, which matches replicating them past the ends.
    function automatic logic [N-1:0] bubble_filter(input logic [N-1:0] s);
        logic [N-1:0] r;
        r = s;
        for (int i = 1; i < N - 1; i++) begin
            r[i] = (s[i-1] & s[i]) | (s[i-1] & s[i+1]) | (s[i] & s[i+1]);
        end
        return r;
    endfunction
`endif

    // Lowest tap index whose value differs from tap 0. Returns 0 when no
    // tap differs; the caller only uses the result for real hits.
    function automatic logic [FINE_W-1:0] first_diff(input logic [N-1:0] f);
        logic [FINE_W-1:0] idx;
        idx = {FINE_W{1'b0}};
        for (int i = N - 1; i >= 1; i--) begin
            idx = (f[i] != f[0]) ? FINE_W'(i) : idx;
        end
        return idx;
    endfunction

    logic [COARSE_W-1:0] cc_q, cc_d;
    logic [N-1:0]        s1_q, s2_q, f_q, f_d;
    logic [COARSE_W-1:0] c1_q, c2_q, c3_q;

    logic [ENTRY_W-1:0]  mem_q [DEPTH];
    logic [ENTRY_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                hit_valid_q, hit_valid_d;
    logic [FINE_W-1:0]   hit_fine_q, hit_fine_d;
    logic                hit_rise_q, hit_rise_d;
    logic [COARSE_W-1:0] hit_coarse_q, hit_coarse_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;

    logic                hit_s, full_s, pop_s, push_s, drop_s;
    logic [FINE_W-1:0]   fine_s;
    logic [ENTRY_W-1:0]  entry_s, head_s;

    // Coarse counter advance and the S3 filter stage input.
    always_comb begin
        cc_d = cc_q + COARSE_W'(1);
`ifdef TDC_BUBBLE_FILTER_EN
        f_d = bubble_filter(s2_q);
`else
        f_d = s2_q;
`endif
    end

    // S4 encode plus FIFO push/pop/drop decisions and next storage state.
    always_comb begin
        hit_s    = (f_q != {N{1'b0}}) && (f_q != {N{1'b1}});
        fine_s   = first_diff(f_q);
        entry_s  = {fine_s, f_q[0], c3_q};
        full_s   = (count_q == CNT_W'(DEPTH));
        pop_s    = hit_valid_q && hit_ready;
        push_s   = hit_s && arm && (!full_s || pop_s);
        drop_s   = hit_s && arm && full_s && !pop_s;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_s) begin
            mem_d[wr_ptr_q] = entry_s;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (drop_s && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Next FIFO head into the registered outputs; a push landing in the slot
    // about to be read bypasses storage. Outputs hold while the FIFO is empty.
    always_comb begin
        hit_valid_d  = (count_d != {CNT_W{1'b0}});
        head_s       = {ENTRY_W{1'b0}};
        hit_fine_d   = hit_fine_q;
        hit_rise_d   = hit_rise_q;
        hit_coarse_d = hit_coarse_q;
        if (hit_valid_d) begin
            if (push_s && (wr_ptr_q == rd_ptr_d)) begin
                head_s = entry_s;
            end else begin
                head_s = mem_q[rd_ptr_d];
            end
            {hit_fine_d, hit_rise_d, hit_coarse_d} = head_s;
        end else begin
            head_s = {ENTRY_W{1'b0}};
        end
    end

    // Pipeline, coarse counter, FIFO control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q         <= {COARSE_W{1'b0}};
            s1_q         <= {N{1'b0}};
            s2_q         <= {N{1'b0}};
            f_q          <= {N{1'b0}};
            c1_q         <= {COARSE_W{1'b0}};
            c2_q         <= {COARSE_W{1'b0}};
            c3_q         <= {COARSE_W{1'b0}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            hit_valid_q  <= 1'b0;
            hit_fine_q   <= {FINE_W{1'b0}};
            hit_rise_q   <= 1'b0;
            hit_coarse_q <= {COARSE_W{1'b0}};
            drop_cnt_q   <= 8'd0;
        end else begin
            cc_q         <= cc_d;
            s1_q         <= taps;
            s2_q         <= s1_q;
            f_q          <= f_d;
            c1_q         <= cc_q;
            c2_q         <= c1_q;
            c3_q         <= c2_q;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hit_valid_q  <= hit_valid_d;
            hit_fine_q   <= hit_fine_d;
            hit_rise_q   <= hit_rise_d;
            hit_coarse_q <= hit_coarse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign hit_valid  = hit_valid_q;
    assign hit_fine   = hit_fine_q;
    assign hit_rise   = hit_rise_q;
    assign hit_coarse = hit_coarse_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_tdc_therm_encoder.sv
// Directed self-checking bench for tdc_therm_encoder. A 10-bit coarse
// counter is used so that the wrap case is reached in about a thousand
// cycles; everything else runs with the default tap count and FIFO depth.
module tb_tdc_therm_encoder;

    localparam int N     = 128;
    localparam int CW    = 10;
    localparam int DEPTH = 4;
    localparam int FW    = $clog2(N);

    logic          clk;
    logic          rst;
    logic [N-1:0]  taps;
    logic          arm;
    logic          hit_valid;
    logic          hit_ready;
    logic [FW-1:0] hit_fine;
    logic          hit_rise;
    logic [CW-1:0] hit_coarse;
    logic [7:0]    drop_cnt;

    int            checks;
    int            errors;
    logic [CW-1:0] cc_m;

    tdc_therm_encoder #(.N(N), .COARSE_W(CW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .taps       (taps),
        .arm        (arm),
        .hit_valid  (hit_valid),
        .hit_ready  (hit_ready),
        .hit_fine   (hit_fine),
        .hit_rise   (hit_rise),
        .hit_coarse (hit_coarse),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; cc_m tracks the counter value present at the next edge.
    task automatic tick();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        cc_m = r ? {CW{1'b0}} : cc_m + CW'(1);
    endtask

    function automatic logic [N-1:0] therm(input int k);
        logic [N-1:0] v;
        v = {N{1'b0}};
        for (int i = 0; i < k; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Present one snapshot for a single edge; c is the coarse count it sees.
    task automatic snap(input logic [N-1:0] t, output logic [CW-1:0] c);
        taps = t;
        c    = cc_m;
        tick();
        taps = {N{1'b0}};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b0; hit_ready = 1'b0; taps = {N{1'b0}};
        repeat (3) tick();
        checks++;
        if (hit_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", hit_valid); end
        checks++;
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
        checks++;
        if ({hit_fine, hit_rise, hit_coarse} !== {(FW + 1 + CW){1'b0}}) begin
            errors++; $display("FAIL reset_fields: fine %0d rise %0b coarse %0d expected all 0", hit_fine, hit_rise, hit_coarse);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (hit_valid !== 1'b0) begin errors++; $display("FAIL idle_valid cycle %0d: got %0b expected 0", i, hit_valid); end
        end
        checks++;
        if ({drop_cnt, hit_fine, hit_coarse} !== {(8 + FW + CW){1'b0}}) begin
            errors++; $display("FAIL idle_fields: drop %0d fine %0d coarse %0d expected 0", drop_cnt, hit_fine, hit_coarse);
        end
    endtask

    task automatic test_single_hit();
        logic [CW-1:0] c;
        do_reset();
        arm = 1'b1; hit_ready = 1'b0;
        repeat (10) tick();
        snap(therm(4), c);
        tick(); tick();
        checks++;
        if (hit_valid !== 1'b0) begin errors++; $display("FAIL single_early: valid %0b two edges after snapshot, expected 0", hit_valid); end
        tick();
        checks++;
        if (hit_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", hit_valid); end
        checks++;
        if (hit_fine !== FW'(4)) begin errors++; $display("FAIL single_fine: got %0d expected 4", hit_fine); end
        checks++;
        if (hit_rise !== 1'b1) begin errors++; $display("FAIL single_rise: got %0b expected 1", hit_rise); end
        checks++;
        if (hit_coarse !== CW'(10)) begin errors++; $display("FAIL single_coarse: got %0d expected 10", hit_coarse); end
        hit_ready = 1'b1;
        tick();
        hit_ready = 1'b0;
        checks++;
        if (hit_valid !== 1'b0) begin errors++; $display("FAIL single_pop: valid %0b expected 0", hit_valid); end
        checks++;
        if (hit_fine !== FW'(4) || hit_coarse !== CW'(10)) begin
            errors++; $display("FAIL single_hold: fine %0d coarse %0d expected 4 and 10", hit_fine, hit_coarse);
        end
    endtask

    task automatic test_no_hit();
        logic [CW-1:0] c;
        snap({N{1'b1}}, c);
        snap({N{1'b1}}, c);
        repeat (4) tick();
        checks++;
        if (hit_valid !== 1'b0) begin errors++; $display("FAIL all_ones_nohit: valid %0b expected 0", hit_valid); end
    endtask

    task automatic test_bubble();
        logic [N-1:0]  t;
        logic [CW-1:0] c;
        logic [FW-1:0] exp_fine;
        t = {N{1'b0}};
        t[9:0] = 10'h3DF;
`ifdef TDC_BUBBLE_FILTER_EN
        exp_fine = FW'(10);
`else
        exp_fine = FW'(5);
`endif
        snap(t, c);
        repeat (3) tick();
        checks++;
        if (hit_valid !== 1'b1 || hit_fine !== exp_fine || hit_rise !== 1'b1) begin
            errors++; $display("FAIL bubble: valid %0b fine %0d rise %0b expected 1 %0d 1", hit_valid, hit_fine, hit_rise, exp_fine);
        end
        hit_ready = 1'b1; tick(); hit_ready = 1'b0;
    endtask

    task automatic test_polarity();
        logic [N-1:0]  t;
        logic [CW-1:0] c0, c1;
        t = ~therm(8);
        snap(t, c0);
        t = therm(N - 1);
        snap(t, c1);
        repeat (3) tick();
        checks++;
        if (hit_fine !== FW'(8) || hit_rise !== 1'b0 || hit_coarse !== c0) begin
            errors++; $display("FAIL falling_edge: fine %0d rise %0b coarse %0d expected 8 0 %0d", hit_fine, hit_rise, hit_coarse, c0);
        end
        hit_ready = 1'b1; tick(); hit_ready = 1'b0;
        checks++;
        if (hit_valid !== 1'b1 || hit_fine !== FW'(N - 1) || hit_rise !== 1'b1 || hit_coarse !== c1) begin
            errors++; $display("FAIL top_tap: valid %0b fine %0d rise %0b coarse %0d expected 1 %0d 1 %0d", hit_valid, hit_fine, hit_rise, hit_coarse, N - 1, c1);
        end
        hit_ready = 1'b1; tick(); hit_ready = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic [CW-1:0] c [6];
        hit_ready = 1'b0;
        for (int i = 0; i < 6; i++) snap(therm(i + 1), c[i]);
        repeat (3) tick();
        checks++;
        if (drop_cnt !== 8'd2) begin errors++; $display("FAIL full_drop: got %0d expected 2", drop_cnt); end
        hit_ready = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
            checks++;
            if (hit_valid !== 1'b1 || hit_fine !== FW'(j + 1) || hit_coarse !== c[j]) begin
                errors++; $display("FAIL full_order %0d: valid %0b fine %0d coarse %0d expected 1 %0d %0d", j, hit_valid, hit_fine, hit_coarse, j + 1, c[j]);
            end
            tick();
        end
        hit_ready = 1'b0;
        checks++;
        if (hit_valid !== 1'b0) begin errors++; $display("FAIL full_drained: valid %0b expected 0", hit_valid); end
    endtask

    task automatic test_full_pop();
        logic [CW-1:0] c [5];
        hit_ready = 1'b0;
        for (int i = 0; i < 5; i++) snap(therm(7 + i), c[i]);
        tick(); tick();
        checks++;
        if (hit_valid !== 1'b1 || hit_fine !== FW'(7)) begin
            errors++; $display("FAIL fullpop_head: valid %0b fine %0d expected 1 7", hit_valid, hit_fine);
        end
        hit_ready = 1'b1;
        tick();
        checks++;
        if (drop_cnt !== 8'd2) begin errors++; $display("FAIL fullpop_drop: got %0d expected 2", drop_cnt); end
        for (int j = 1; j < 5; j++) begin
            checks++;
            if (hit_valid !== 1'b1 || hit_fine !== FW'(7 + j) || hit_coarse !== c[j]) begin
                errors++; $display("FAIL fullpop_order %0d: valid %0b fine %0d coarse %0d expected 1 %0d %0d", j, hit_valid, hit_fine, hit_coarse, 7 + j, c[j]);
            end
            tick();
        end
        hit_ready = 1'b0;
        checks++;
        if (hit_valid !== 1'b0) begin errors++; $display("FAIL fullpop_drained: valid %0b expected 0", hit_valid); end
    endtask

    task automatic test_disarmed();
        logic [CW-1:0] c;
        arm = 1'b0;
        snap(therm(3), c);
        repeat (4) tick();
        checks++;
        if (hit_valid !== 1'b0) begin errors++; $display("FAIL disarmed_queue: valid %0b expected 0", hit_valid); end
        arm = 1'b1;
        for (int i = 0; i < DEPTH; i++) snap(therm(20 + i), c);
        repeat (3) tick();
        arm = 1'b0;
        snap(therm(30), c);
        repeat (4) tick();
        checks++;
        if (drop_cnt !== 8'd2 || hit_fine !== FW'(20)) begin
            errors++; $display("FAIL disarmed_full: drop %0d head %0d expected 2 20", drop_cnt, hit_fine);
        end
        hit_ready = 1'b1;
        repeat (DEPTH) tick();
        hit_ready = 1'b0;
        arm = 1'b1;
        checks++;
        if (hit_valid !== 1'b0 || hit_fine !== FW'(23)) begin
            errors++; $display("FAIL disarmed_drain: valid %0b last fine %0d expected 0 23", hit_valid, hit_fine);
        end
    endtask

    task automatic test_wrap();
        logic [CW-1:0] c0, c1;
        hit_ready = 1'b0;
        for (int i = 0; i < (1 << CW) + 4 && cc_m != {CW{1'b1}}; i++) tick();
        checks++;
        if (cc_m != {CW{1'b1}}) begin errors++; $display("FAIL wrap_timeout: counter model at %0d", cc_m); end
        snap(therm(2), c0);
        snap(therm(5), c1);
        repeat (3) tick();
        checks++;
        if (hit_fine !== FW'(2) || hit_coarse !== {CW{1'b1}}) begin
            errors++; $display("FAIL wrap_first: fine %0d coarse %0h expected 2 %0h", hit_fine, hit_coarse, {CW{1'b1}});
        end
        hit_ready = 1'b1; tick(); hit_ready = 1'b0;
        checks++;
        if (hit_valid !== 1'b1 || hit_fine !== FW'(5) || hit_coarse !== {CW{1'b0}}) begin
            errors++; $display("FAIL wrap_second: valid %0b fine %0d coarse %0h expected 1 5 0", hit_valid, hit_fine, hit_coarse);
        end
        hit_ready = 1'b1; tick(); hit_ready = 1'b0;
    endtask

    task automatic test_reset_inflight();
        logic [CW-1:0] c;
        snap(therm(6), c);
        repeat (3) tick();
        checks++;
        if (hit_valid !== 1'b1) begin errors++; $display("FAIL inflight_setup: valid %0b expected 1", hit_valid); end
        snap(therm(3), c);
        snap(therm(4), c);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (hit_valid !== 1'b0) begin errors++; $display("FAIL inflight_valid cycle %0d: got %0b expected 0", i, hit_valid); end
        end
        checks++;
        if (hit_fine !== FW'(0) || drop_cnt !== 8'd0) begin
            errors++; $display("FAIL inflight_fields: fine %0d drop %0d expected 0 0", hit_fine, drop_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; arm = 1'b0; hit_ready = 1'b0; taps = {N{1'b0}};
        cc_m = {CW{1'b0}};
        test_reset();
        test_single_hit();
        test_no_hit();
        test_bubble();
        test_polarity();
        test_fifo_full();
        test_full_pop();
        test_disarmed();
        test_wrap();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
